load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Memory-access stage directly downstream of the instruction decoder. Consumes the decoder's load/store request, access size, signedness and misalignment flags plus the computed effective address. Runs one data-bus transaction per instruction with a request/acknowledge handshake, stalling the pipeline until it completes. Returns aligned, sign/zero-extended load data to writeback, and flags bus timeouts as access faults.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in REQ without dbus_ack_in before a fault (1..255, 8-bit counter)

Ports:
clk_in  input  1  clock, all state updates on rising edge
reset_in  input  1  synchronous, active-high reset
ld_req_in  input  1  decoded load valid this cycle
st_req_in  input  1  decoded store valid this cycle
misaligned_in  input  1  OR of decoder misaligned_load/misaligned_store; suppresses access
flush_in  input  1  trap/flush; suppresses acceptance and result pulse
load_size_in  input  2  00 byte, 01 half, 10/11 word
load_unsigned_in  input  1  1 = zero-extend load result
addr_in  input  32  effective address
store_data_in  input  32  rs2 value
dbus_addr_out  output  32  word-aligned address {addr[31:2],2'b00}
dbus_wdata_out  output  32  lane-replicated store data
dbus_wr_mask_out  output  4  byte-lane enables (stores only; 0 for loads)
dbus_rd_req_out  output  1  read request, held until ack
dbus_wr_req_out  output  1  write request, held until ack
dbus_ack_in  input  1  transaction complete; rdata valid same cycle for reads
dbus_rdata_in  input  32  read data word
stall_out  output  1  freeze upstream stages
lsu_data_out  output  32  extended load result
lsu_valid_out  output  1  one-cycle completion pulse
access_fault_out  output  1  one-cycle timeout pulse

Behaviour:
- States: IDLE, REQ, DONE. Reset -> IDLE; all outputs 0, timeout counter 0.
- accept = IDLE & (ld_req_in|st_req_in) & ~misaligned_in & ~flush_in. Both ld and st set: treat as store.
- On accept: register aligned address, offset addr[1:0], size, unsigned, direction, mask and wdata; go REQ.
- stall_out = accept (combinational, same cycle) | (state==REQ). Deasserted in DONE.
- Mask: byte 4'b0001<<offset; half offset[1]?4'b1100:4'b0011; word 4'b1111. Half/word ignore offset low bits (decoder already filters misalignment).
- Wdata: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
- REQ: rd_req or wr_req =1; addr/wdata/mask held stable until ack. Counter increments each REQ cycle without ack.
- Ack in REQ: load -> select lane (byte = rdata[8*off+7:8*off]; half = off[1]?rdata[31:16]:rdata[15:0]; word = rdata), extend per load_unsigned, register into lsu_data_out; stores leave lsu_data_out=0. Drop request, go DONE.
- Timeout: counter == TIMEOUT_CYCLES-1 with no ack -> drop request, set fault flag, go DONE; lsu_data_out=0.
- DONE (exactly 1 cycle): lsu_valid_out=1 (or access_fault_out=1 on timeout, never both); counter cleared; next state IDLE. New requests are not accepted in DONE.
- lsu_data_out holds value until next DONE; cleared only by reset.
- flush_in in REQ: bus transaction still completes (no abandonment) but DONE pulses of valid and fault are suppressed.
- Ack in IDLE/DONE: ignored.
- reset_in mid-REQ: next edge -> IDLE, requests drop, no pulse.
- Latency: accept in cycle N, ack in N+k (k>=1) -> valid pulse in N+k+1.

Test Plan:
- LB addr=0x1003, unsigned=0, rdata=0x80AA_BBCC, ack after 2 cycles -> dbus_addr=0x1000, mask=0, lsu_data=0xFFFF_FF80, valid 1 cycle, stall high 3 cycles.
- LHU addr=0x2002, rdata=0xBEEF_1234 -> lsu_data=0x0000_BEEF; LH same -> 0xFFFF_BEEF.
- SB addr=0x3001, data=0x1234_56A5 -> wr_req=1, mask=0010, wdata=0xA5A5_A5A5, held until ack; SW -> mask=1111, wdata=data.
- misaligned_in=1 with LW -> no bus request, stall_out=0, no valid pulse; flush_in in REQ -> transaction completes, no pulse.
- TIMEOUT_CYCLES=4, no ack -> request drops after 4 REQ cycles, access_fault_out=1 one cycle, lsu_valid_out=0.
- reset_in asserted during REQ -> next cycle all outputs 0, state IDLE; subsequent LW completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Data-bus bundle between the load/store unit (master) and the memory port (slave).
// Signal names keep their LSU-side direction suffixes so both ends read the same.
interface load_store_unit_if;
  logic [31:0] dbus_addr_out;
  logic [31:0] dbus_wdata_out;
  logic [3:0]  dbus_wr_mask_out;
  logic        dbus_rd_req_out;
  logic        dbus_wr_req_out;
  logic        dbus_ack_in;
  logic [31:0] dbus_rdata_in;

  modport master (
    output dbus_addr_out, dbus_wdata_out, dbus_wr_mask_out, dbus_rd_req_out, dbus_wr_req_out,
    input  dbus_ack_in, dbus_rdata_in
  );

  modport slave (
    input  dbus_addr_out, dbus_wdata_out, dbus_wr_mask_out, dbus_rd_req_out, dbus_wr_req_out,
    output dbus_ack_in, dbus_rdata_in
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one request/ack bus transaction per load or store, pipeline stall
// while it is outstanding, lane-aligned extended load data and a timeout access fault.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              ld_req_in,
  input  logic              st_req_in,
  input  logic              misaligned_in,
  input  logic              flush_in,
  input  logic [1:0]        load_size_in,
  input  logic              load_unsigned_in,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       store_data_in,
  load_store_unit_if.master dbus,
  output logic              stall_out,
  output logic [31:0]       lsu_data_out,
  output logic              lsu_valid_out,
  output logic              access_fault_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   lane_wdata = {4{d[7:0]}};
      2'b01:   lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] off,
                                               input logic uns, input logic [31:0] rdata);
    logic [31:0] sh;
    logic [15:0] half;
    sh   = rdata >> {off, 3'b000};
    half = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   load_extract = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   load_extract = uns ? {16'h0000, half} : {{16{half[15]}}, half};
      default: load_extract = rdata;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        store_q, store_d;
  logic        rd_req_q, rd_req_d;
  logic        wr_req_q, wr_req_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        supp_q, supp_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic        accept_s;
  logic        supp_next_s;

  assign accept_s = (state_q == S_IDLE) & (ld_req_in | st_req_in) & ~misaligned_in & ~flush_in;
  assign supp_next_s = supp_q | flush_in;

  // Next-state and next-output computation for the IDLE/REQ/DONE sequence.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    off_d    = off_q;
    size_d   = size_q;
    uns_d    = uns_q;
    store_d  = store_q;
    rd_req_d = rd_req_q;
    wr_req_d = wr_req_q;
    cnt_d    = cnt_q;
    supp_d   = supp_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    fault_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          // Simultaneous load and store is resolved as a store.
          addr_d   = {addr_in[31:2], 2'b00};
          off_d    = addr_in[1:0];
          size_d   = load_size_in;
          uns_d    = load_unsigned_in;
          store_d  = st_req_in;
          mask_d   = st_req_in ? lane_mask(load_size_in, addr_in[1:0]) : 4'b0000;
          wdata_d  = st_req_in ? lane_wdata(load_size_in, store_data_in) : 32'h0000_0000;
          rd_req_d = ~st_req_in;
          wr_req_d = st_req_in;
          cnt_d    = 8'd0;
          supp_d   = 1'b0;
          state_d  = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (dbus.dbus_ack_in) begin
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          data_d   = store_q ? 32'h0000_0000 : load_extract(size_q, off_q, uns_q, dbus.dbus_rdata_in);
          valid_d  = ~supp_next_s;
          cnt_d    = 8'd0;
          supp_d   = 1'b0;
          state_d  = S_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          data_d   = 32'h0000_0000;
          fault_d  = ~supp_next_s;
          cnt_d    = 8'd0;
          supp_d   = 1'b0;
          state_d  = S_DONE;
        end else begin
          cnt_d  = cnt_q + 8'd1;
          supp_d = supp_next_s;
        end
      end
      S_DONE: begin
        cnt_d   = 8'd0;
        supp_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        rd_req_d = 1'b0;
        wr_req_d = 1'b0;
        cnt_d    = 8'd0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'h0000_0000;
      wdata_q  <= 32'h0000_0000;
      mask_q   <= 4'b0000;
      off_q    <= 2'b00;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      store_q  <= 1'b0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      cnt_q    <= 8'd0;
      supp_q   <= 1'b0;
      data_q   <= 32'h0000_0000;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      off_q    <= off_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      store_q  <= store_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      cnt_q    <= cnt_d;
      supp_q   <= supp_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
    end
  end

  assign dbus.dbus_addr_out    = addr_q;
  assign dbus.dbus_wdata_out   = wdata_q;
  assign dbus.dbus_wr_mask_out = mask_q;
  assign dbus.dbus_rd_req_out  = rd_req_q;
  assign dbus.dbus_wr_req_out  = wr_req_q;
  // Stall must rise in the accept cycle itself so upstream never advances past the access.
  assign stall_out        = accept_s | (state_q == S_REQ);
  assign lsu_data_out     = data_q;
  assign lsu_valid_out    = valid_q;
  assign access_fault_out = fault_q;

endmodule
